// File: rtl/iodelay_tune_if.sv
// Programming/observation bundle between the IO delay training controller
// and its user (start/pattern in, tap/strobe/status out, lane data loopback).
`timescale 1ns/1ps
interface iodelay_tune_if #(
    parameter int P_DATA_NBIT  = 8,
    parameter int P_DELAY_NBIT = 4
);
    localparam int NTAP = 2 ** P_DELAY_NBIT;

    // Handshake: in_start is a one-cycle request, accepted only while
    // out_busy is low; out_done is a level that stays high with
    // out_fail/out_pass_map/out_delay valid until the next accepted start.
    logic                    in_start;
    logic [P_DATA_NBIT-1:0]  in_pattern;
    logic [P_DATA_NBIT-1:0]  in_dio;
    logic [P_DELAY_NBIT-1:0] out_delay;
    logic                    out_delay_we;
    logic                    out_busy;
    logic                    out_done;
    logic                    out_fail;
    logic [NTAP-1:0]         out_pass_map;
    logic [3:0]              dbg_state;

    modport slave (
        input  in_start, in_pattern, in_dio,
        output out_delay, out_delay_we, out_busy, out_done, out_fail,
               out_pass_map, dbg_state
    );

    modport master (
        output in_start, in_pattern, in_dio,
        input  out_delay, out_delay_we, out_busy, out_done, out_fail,
               out_pass_map, dbg_state
    );
endinterface

// File: rtl/iodelay_tune.sv
// IO delay training controller: sweeps every tap, checks looped-back data
// against a training word, then programs the centre of the widest window.
`timescale 1ns/1ps
module iodelay_tune #(
    parameter int P_DATA_NBIT  = 8,
    parameter int P_DELAY_NBIT = 4,
    parameter int P_WE_HOLD    = 4,
    parameter int P_SETTLE     = 24,
    parameter int P_CHECK      = 64
) (
    input  logic           clk,
    input  logic           rst,
    iodelay_tune_if.slave  bus
);
    localparam int NTAP     = 2 ** P_DELAY_NBIT;
    localparam int M1       = (P_SETTLE > P_CHECK) ? P_SETTLE : P_CHECK;
    localparam int M2       = (M1 > P_WE_HOLD + 1) ? M1 : P_WE_HOLD + 1;
    localparam int CNT_NBIT = $clog2(M2 + 1);
    localparam int LEN_NBIT = P_DELAY_NBIT + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WRITE, S_SETTLE, S_CHECK,
        S_NEXT, S_EVAL, S_APPLY, S_APPLY_WAIT, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [P_DELAY_NBIT-1:0] tap_q, tap_d;
    logic [CNT_NBIT-1:0]     cnt_q, cnt_d;
    logic [P_DATA_NBIT-1:0]  pattern_q, pattern_d;
    logic [NTAP-1:0]         map_q, map_d;
    logic                    pass_q, pass_d;
    logic [P_DELAY_NBIT-1:0] delay_q, delay_d;
    logic                    we_q, we_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    fail_q, fail_d;
    logic [P_DELAY_NBIT-1:0] run_start_q, run_start_d;
    logic [LEN_NBIT-1:0]     run_len_q, run_len_d;
    logic [P_DELAY_NBIT-1:0] best_start_q, best_start_d;
    logic [LEN_NBIT-1:0]     best_len_q, best_len_d;

    logic [LEN_NBIT-1:0]     new_len;
    logic [P_DELAY_NBIT-1:0] new_start;
    logic [LEN_NBIT-1:0]     best_tap;

    // State register; reset aborts a sweep at once and drops all outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tap_q        <= '0;
            cnt_q        <= '0;
            pattern_q    <= '0;
            map_q        <= '0;
            pass_q       <= 1'b0;
            delay_q      <= '0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            cnt_q        <= cnt_d;
            pattern_q    <= pattern_d;
            map_q        <= map_d;
            pass_q       <= pass_d;
            delay_q      <= delay_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    // Next-state logic: sweep, window scan, and final programming of the best tap
    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        cnt_d        = cnt_q;
        pattern_d    = pattern_q;
        map_d        = map_q;
        pass_d       = pass_q;
        delay_d      = delay_q;
        busy_d       = busy_q;
        done_d       = done_q;
        fail_d       = fail_q;
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        new_len      = '0;
        new_start    = '0;
        best_tap     = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.in_start) begin
                    pattern_d = bus.in_pattern;
                    map_d     = '0;
                    tap_d     = '0;
                    delay_d   = '0;
                    done_d    = 1'b0;
                    fail_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            // out_delay already carries the tap here; the strobe follows a cycle later
            S_LOAD: begin
                cnt_d   = CNT_NBIT'(P_WE_HOLD - 1);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_NBIT'(P_SETTLE - 1);
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q - CNT_NBIT'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_NBIT'(P_CHECK - 1);
                    pass_d  = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_NBIT'(1);
                end
            end
            // Full-length compare: a single bad sample fails the tap, no early exit
            S_CHECK: begin
                if (bus.in_dio != pattern_q) begin
                    pass_d = 1'b0;
                end
                if (cnt_q == '0) begin
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q - CNT_NBIT'(1);
                end
            end
            S_NEXT: begin
                map_d[tap_q] = pass_q;
                if (tap_q == P_DELAY_NBIT'(NTAP - 1)) begin
                    tap_d        = '0;
                    run_start_d  = '0;
                    run_len_d    = '0;
                    best_start_d = '0;
                    best_len_d   = '0;
                    state_d      = S_EVAL;
                end else begin
                    tap_d   = tap_q + P_DELAY_NBIT'(1);
                    delay_d = tap_q + P_DELAY_NBIT'(1);
                    state_d = S_LOAD;
                end
            end
            // One map bit per cycle; strict '>' keeps the lower start on ties
            S_EVAL: begin
                if (map_q[tap_q]) begin
                    new_len     = run_len_q + LEN_NBIT'(1);
                    new_start   = (run_len_q == '0) ? tap_q : run_start_q;
                    run_len_d   = new_len;
                    run_start_d = new_start;
                    if (new_len > best_len_q) begin
                        best_len_d   = new_len;
                        best_start_d = new_start;
                    end
                end else begin
                    run_len_d = '0;
                end
                if (tap_q == P_DELAY_NBIT'(NTAP - 1)) begin
                    if (best_len_d == '0) begin
                        fail_d   = 1'b1;
                        best_tap = '0;
                    end else begin
                        best_tap = {1'b0, best_start_d} + ((best_len_d - LEN_NBIT'(1)) >> 1);
                    end
                    delay_d = best_tap[P_DELAY_NBIT-1:0];
                    cnt_d   = CNT_NBIT'(P_WE_HOLD);
                    state_d = S_APPLY;
                end else begin
                    tap_d = tap_q + P_DELAY_NBIT'(1);
                end
            end
            // First APPLY cycle is the setup cycle, the remaining P_WE_HOLD strobe
            S_APPLY: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_NBIT'(P_SETTLE - 1);
                    state_d = S_APPLY_WAIT;
                end else begin
                    cnt_d = cnt_q - CNT_NBIT'(1);
                end
            end
            S_APPLY_WAIT: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_NBIT'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobe is registered so it is glitch-free towards the delay line
        we_d = (state_d == S_WRITE) ||
               ((state_d == S_APPLY) && (cnt_d != CNT_NBIT'(P_WE_HOLD)));
    end

    assign bus.out_delay    = delay_q;
    assign bus.out_delay_we = we_q;
    assign bus.out_busy     = busy_q;
    assign bus.out_done     = done_q;
    assign bus.out_fail     = fail_q;
    assign bus.out_pass_map = map_q;
    assign bus.dbg_state    = state_q;
endmodule
